// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: shared definitions for the E-stage multiply/divide unit.
//   - MDUOp encodings (MDU_NONE .. MDU_MTLO)
//   - mdu_mul / mdu_div helpers producing the 64-bit {HI, LO} result
package e_mdu_pkg;

  localparam int MDU_OP_W = 4;

  localparam logic [MDU_OP_W-1:0] MDU_NONE  = 4'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULT  = 4'd1;
  localparam logic [MDU_OP_W-1:0] MDU_MULTU = 4'd2;
  localparam logic [MDU_OP_W-1:0] MDU_DIV   = 4'd3;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 4'd4;
  localparam logic [MDU_OP_W-1:0] MDU_MFHI  = 4'd5;
  localparam logic [MDU_OP_W-1:0] MDU_MFLO  = 4'd6;
  localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 4'd7;
  localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 4'd8;

  // 32x32 -> 64 product; operands are sign- or zero-extended to 64 bits
  // so the low 64 bits of the product are exact in both modes.
  function automatic logic [63:0] mdu_mul(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        is_signed);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = is_signed ? {{32{a[31]}}, a} : {32'h0, a};
    eb = is_signed ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}. Signed division is done on magnitudes
  // and the signs are restored afterwards: quotient is negative when the
  // operand signs differ, remainder follows the dividend. This also makes
  // 0x80000000 / -1 wrap to 0x80000000 with remainder 0 without a special
  // case. A zero divisor yields 0; the caller suppresses the write anyway.
  function automatic logic [63:0] mdu_div(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        is_signed);
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;
    ma = (is_signed && a[31]) ? (32'h0 - a) : a;
    mb = (is_signed && b[31]) ? (32'h0 - b) : b;
    q  = 32'h0;
    r  = 32'h0;
    if (mb != 32'h0) begin
      q = ma / mb;
      r = ma % mb;
    end
    if (is_signed && (a[31] ^ b[31])) q = 32'h0 - q;
    if (is_signed && a[31])           r = 32'h0 - r;
    return {r, q};
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// e_mdu_if: E-stage connection to the multiply/divide unit.
//   Req    : flush of the instruction currently in E (exception/interrupt)
//   start  : E-stage mult/multu/div/divu wants to issue this cycle
//   MDUOp  : operation code (see e_mdu_pkg)
//   A, B   : forwarded rs / rt values
//   busy   : an issued mult/div is still counting down
//   MDUOut : combinational mfhi/mflo read data
// Handshake: there is no valid/ready pair. An operation is accepted on the
// clock edge where start is high, busy is low and Req is low; the pipeline's
// hazard unit is responsible for holding md-class instructions while
// (busy || start), so the unit never back-pressures and never queues.
interface e_mdu_if;
  import e_mdu_pkg::*;

  logic                Req;
  logic                start;
  logic [MDU_OP_W-1:0] MDUOp;
  logic [31:0]         A;
  logic [31:0]         B;
  logic                busy;
  logic [31:0]         MDUOut;

  modport master (output Req, start, MDUOp, A, B, input busy, MDUOut);
  modport slave  (input Req, start, MDUOp, A, B, output busy, MDUOut);

endinterface

// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit with HI/LO registers.
//   clk   : single clock, all state on posedge
//   reset : synchronous, active-high; clears HI, LO, counter and result
//   bus   : e_mdu_if.slave (Req, start, MDUOp, A, B in; busy, MDUOut out)
// The full 64-bit result is computed and latched on the issue edge; a
// down-counter models the latency and HI/LO are written on the edge where
// the counter reaches zero, i.e. the same edge busy falls.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  e_mdu_if.slave   bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [63:0]      res_q, res_d;
  // Commit enable for the latched result; cleared for divide by zero so
  // HI/LO survive the full DIV_CYCLES wait untouched.
  logic             wr_q, wr_d;

  logic is_mul;
  logic is_div;
  logic busy;

  assign is_mul = (bus.MDUOp == MDU_MULT) || (bus.MDUOp == MDU_MULTU);
  assign is_div = (bus.MDUOp == MDU_DIV)  || (bus.MDUOp == MDU_DIVU);
  assign busy   = (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    res_d = res_q;
    wr_d  = wr_q;
    if (busy) begin
      // In-flight work belongs to an older, committed instruction, so Req
      // does not cancel it and new starts / moves to HI/LO are ignored.
      cnt_d = cnt_q - CNT_W'(1);
      if ((cnt_q == CNT_W'(1)) && wr_q) begin
        hi_d = res_q[63:32];
        lo_d = res_q[31:0];
      end
    end else if (!bus.Req) begin
      if (bus.start && is_mul) begin
        res_d = mdu_mul(bus.A, bus.B, bus.MDUOp == MDU_MULT);
        wr_d  = 1'b1;
        cnt_d = CNT_W'(MULT_CYCLES);
      end else if (bus.start && is_div) begin
        res_d = mdu_div(bus.A, bus.B, bus.MDUOp == MDU_DIV);
        wr_d  = (bus.B != 32'h0);
        cnt_d = CNT_W'(DIV_CYCLES);
      end else if (bus.MDUOp == MDU_MTHI) begin
        hi_d = bus.A;
      end else if (bus.MDUOp == MDU_MTLO) begin
        lo_d = bus.A;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      hi_q  <= 32'h0;
      lo_q  <= 32'h0;
      res_q <= 64'h0;
      wr_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      res_q <= res_d;
      wr_q  <= wr_d;
    end
  end

  assign bus.busy   = busy;
  assign bus.MDUOut = (bus.MDUOp == MDU_MFHI) ? hi_q :
                      (bus.MDUOp == MDU_MFLO) ? lo_q : 32'h0;

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed and randomized bench for e_mdu. Driver tasks push the
// expected MDUOut reads and busy-pulse lengths into queues; a monitor on
// the falling edge pops and compares them against the DUT.
module tb_e_mdu;
  import e_mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  e_mdu_if bus();

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  int          busy_q[$];
  logic        rd_vld = 1'b0;
  int          busy_run = 0;

  // Architectural model of HI/LO: updated at issue time, since reads only
  // happen once the unit is idle again.
  logic [31:0] hi_m = 32'h0;
  logic [31:0] lo_m = 32'h0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1) begin
        busy_run++;
      end else if (busy_run > 0) begin
        if (busy_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL busy_unexpected: got pulse of %0d cycles, expected none", busy_run);
        end else begin
          check("busy_len", 32'(busy_run), 32'(busy_q.pop_front()));
        end
        busy_run = 0;
      end
      if (rd_vld) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL read_unexpected: got 0x%08h, expected no read", bus.MDUOut);
        end else begin
          check(name_q.pop_front(), bus.MDUOut, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic void model_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, p, q, r;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MDU_MULT:  begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
      MDU_MULTU: begin pu = {32'h0, a} * {32'h0, b}; hi_m = pu[63:32]; lo_m = pu[31:0]; end
      MDU_DIV:   if (b != 32'h0) begin q = sa / sb; r = sa % sb; lo_m = q[31:0]; hi_m = r[31:0]; end
      MDU_DIVU:  if (b != 32'h0) begin lo_m = a / b; hi_m = a % b; end
      default: ;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.Req   = 1'b0;
    bus.MDUOp = MDU_NONE;
    bus.A     = 32'h0;
    bus.B     = 32'h0;
  endtask

  // Caller guarantees the unit is idle when req == 0.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic req);
    bus.start = 1'b1;
    bus.MDUOp = op;
    bus.A     = a;
    bus.B     = b;
    bus.Req   = req;
    if (!req) begin
      model_md(op, a, b);
      busy_q.push_back((op == MDU_MULT || op == MDU_MULTU) ? MC : DC);
    end
    cyc();
    idle_inputs();
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] a, input logic req, input logic take);
    bus.MDUOp = op;
    bus.A     = a;
    bus.Req   = req;
    if (take && !req) begin
      if (op == MDU_MTHI) hi_m = a;
      else                lo_m = a;
    end
    cyc();
    idle_inputs();
  endtask

  task automatic rd(input logic [3:0] op, input logic [31:0] exp, input string nm);
    bus.MDUOp = op;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    rd_vld = 1'b1;
    cyc();
    rd_vld = 1'b0;
    bus.MDUOp = MDU_NONE;
  endtask

  task automatic rd_both(input string nm);
    rd(MDU_MFHI, hi_m, {nm, "_hi"});
    rd(MDU_MFLO, lo_m, {nm, "_lo"});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 64) begin
      cyc();
      n++;
    end
    if (bus.busy) begin
      tests_run++;
      tests_failed++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", n);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    check("reset_busy", 32'(bus.busy), 32'h0);
    rd(MDU_MFHI, 32'h0, "reset_hi");
    rd(MDU_MFLO, 32'h0, "reset_lo");

    // signed / unsigned multiply
    issue(MDU_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
    wait_idle();
    rd(MDU_MFHI, 32'hFFFFFFFF, "mult_hi");
    rd(MDU_MFLO, 32'hFFFFFFFA, "mult_lo");
    issue(MDU_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0);
    wait_idle();
    rd(MDU_MFHI, 32'h00000002, "multu_hi");
    rd(MDU_MFLO, 32'hFFFFFFFA, "multu_lo");

    // signed / unsigned divide
    issue(MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_idle();
    rd(MDU_MFHI, 32'hFFFFFFFF, "div_hi");
    rd(MDU_MFLO, 32'hFFFFFFFD, "div_lo");
    issue(MDU_DIVU, 32'd7, 32'd2, 1'b0);
    wait_idle();
    rd(MDU_MFHI, 32'd1, "divu_hi");
    rd(MDU_MFLO, 32'd3, "divu_lo");

    // Req blocks issue and moves
    issue(MDU_MULT, 32'h12345678, 32'h9, 1'b1);
    check("req_busy", 32'(bus.busy), 32'h0);
    mt(MDU_MTHI, 32'h55, 1'b1, 1'b1);
    rd(MDU_MFHI, 32'd1, "req_hi");
    rd(MDU_MFLO, 32'd3, "req_lo");

    // divide by zero keeps LO from MTLO
    mt(MDU_MTLO, 32'h1234, 1'b0, 1'b1);
    issue(MDU_DIV, 32'd99, 32'h0, 1'b0);
    wait_idle();
    rd(MDU_MFLO, 32'h1234, "div0_lo");
    rd(MDU_MFHI, 32'd1, "div0_hi");

    // overflow case
    issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_idle();
    rd(MDU_MFLO, 32'h80000000, "divovf_lo");
    rd(MDU_MFHI, 32'h0, "divovf_hi");

    // moves and MDUOut decode
    mt(MDU_MTHI, 32'hDEADBEEF, 1'b0, 1'b1);
    rd(MDU_MFHI, 32'hDEADBEEF, "mthi");
    rd(MDU_NONE, 32'h0, "none_out");

    // start and MTLO while busy are ignored; Req mid-flight does not cancel
    issue(MDU_MULT, 32'h7, 32'h6, 1'b0);
    cyc();
    bus.start = 1'b1; bus.MDUOp = MDU_DIV; bus.A = 32'd100; bus.B = 32'd3;
    cyc();
    idle_inputs();
    mt(MDU_MTLO, 32'hCAFE, 1'b0, 1'b0);
    bus.Req = 1'b1;
    cyc();
    bus.Req = 1'b0;
    wait_idle();
    rd_both("busy_start");

    // reset in the middle of a divide
    issue(MDU_DIV, 32'd1000, 32'd7, 1'b0);
    void'(busy_q.pop_back());
    busy_q.push_back(3);
    cyc();
    cyc();
    reset = 1'b1;
    hi_m = 32'h0;
    lo_m = 32'h0;
    cyc();
    reset = 1'b0;
    check("rst_mid_busy", 32'(bus.busy), 32'h0);
    repeat (12) cyc();
    rd_both("rst_mid");

    // randomized operations
    for (int i = 0; i < 30; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(1, 4));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'($urandom_range(1, 16));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0)
        mt(($urandom_range(0, 1) == 0) ? MDU_MTHI : MDU_MTLO, $urandom, 1'($urandom_range(0, 1)), 1'b1);
      issue(op, a, b, 1'($urandom_range(0, 5) == 0));
      wait_idle();
      rd_both("rand");
    end

    repeat (3) cyc();
    tests_run++;
    if (busy_q.size() != 0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL queues_drained: got busy_q=%0d exp_q=%0d, expected 0 0", busy_q.size(), exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: E_MDU

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy duration of mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy duration of div/divu.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port Req  in  1  exception/interrupt request; the instruction currently in E is being flushed.
REQ-006 SHALL have port start  in  1  E-stage instruction is mult/multu/div/divu and is to issue this cycle.
REQ-007 SHALL have port MDUOp  in  4  operation code: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
REQ-008 SHALL have port A  in  32  forwarded rs value of the E-stage instruction.
REQ-009 SHALL have port B  in  32  forwarded rt value of the E-stage instruction.
REQ-010 SHALL have port busy  out  1  high while an issued mult/div is in progress.
REQ-011 SHALL have port MDUOut  out  32  mfhi/mflo read data.

Function
REQ-012 Issue condition SHALL be: start && !busy && !Req && MDUOp in {MULT, MULTU, DIV, DIVU}.
REQ-013 On issue, the block SHALL latch the full 64-bit result and load a counter with MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu).
REQ-014 busy SHALL equal (counter != 0): high for exactly N cycles after the issue edge.
REQ-015 The counter SHALL decrement by 1 each cycle while nonzero.
REQ-016 On the edge where the counter goes 1->0, HI/LO SHALL be written with the latched result, so HI/LO change on the same edge busy falls.
REQ-017 MULT SHALL compute the signed 32x32->64 product; MULTU SHALL compute the unsigned product; HI = [63:32], LO = [31:0].
REQ-018 DIV/DIVU SHALL set LO = quotient truncated toward zero and HI = remainder; for DIV the remainder takes the sign of the dividend.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-020 Divide by zero (B==0) SHALL still hold busy for DIV_CYCLES, with HI/LO left unchanged at completion.
REQ-021 start asserted while busy SHALL be ignored: no relatch and no counter reload.
REQ-022 MTHI/MTLO SHALL write A to HI/LO at the next edge only when !busy && !Req; otherwise they SHALL be ignored.
REQ-023 Req SHALL NOT cancel an operation already in progress, because it belongs to an older, committed instruction.
REQ-024 MDUOut SHALL be combinational: HI when MDUOp==MFHI, LO when MDUOp==MFLO, else 0.
REQ-025 The hazard unit, not this block, SHALL stall D while an E-stage md-class instruction sees (busy || start); the block SHALL rely on no other handshake.

Reset
REQ-026 reset SHALL clear at the next edge: HI=0, LO=0, counter=0, latched result=0, busy=0.
REQ-027 reset SHALL take priority over issue, MTHI/MTLO and completion.
REQ-028 reset mid-operation SHALL abort the operation, with no HI/LO write afterwards.
REQ-029 MDUOut after reset SHALL read 0 for MFHI/MFLO.

Structure
REQ-030 MDUOp encodings SHALL live in the shared constants.v include (MDU_NONE=0 .. MDU_MTLO=8); MULT_CYCLES and DIV_CYCLES SHALL remain module parameters.
REQ-031 The block SHALL be a single module with no sub-module; it is instantiated in the E stage beside the ALU, fed by E_REG rs/rt values.

Verification
REQ-032 MULT A=0xFFFFFFFE, B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-033 DIV A=0xFFFFFFF9, B=2 -> busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=2 -> LO=3, HI=1.
REQ-034 start=1 with MULT and Req=1 -> busy stays 0 and HI/LO unchanged; MTHI 0x55 with Req=1 -> HI unchanged.
REQ-035 DIV issued, reset asserted 3 cycles later -> next cycle busy=0, HI=LO=0, and no later write occurs.
REQ-036 DIV with B=0 after MTLO 0x1234 -> busy high 10 cycles, then LO=0x1234; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-037 MTHI 0xDEADBEEF then MFHI -> MDUOut=0xDEADBEEF; start issued while busy -> counter not reloaded and original result committed.
